// File: rtl/width_packer.sv
// width_packer: collects narrow val/rdy lanes into RATIO-lane wide words.
// Lane 0 is in the LSBs. A word is emitted when it fills, when a lane carries
// end-of-packet, or when a flush is requested. A partial word reports its lane
// count in o_cnt, and the unused upper lanes are zero.
module width_packer #(
    parameter int IN_BITS = 8,
    parameter int RATIO   = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_val,
    input  logic [IN_BITS-1:0]           i_dat,
    input  logic                         i_eop,
    output logic                         o_rdy,
    input  logic                         i_flush,
    output logic                         o_val,
    output logic [IN_BITS*RATIO-1:0]     o_dat,
    output logic                         o_eop,
    output logic [$clog2(RATIO+1)-1:0]   o_cnt,
    input  logic                         i_rdy
);

    localparam int CNT_W    = $clog2(RATIO + 1);
    localparam int OUT_BITS = IN_BITS * RATIO;
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // A single-lane "word" is meaningless; stop elaboration outright.
    if (RATIO < 2) begin : g_ratio_check
        $fatal(1, "width_packer: RATIO must be at least 2");
    end

    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [OUT_BITS-1:0] acc_reg, acc_next;
    logic                o_val_reg, o_val_next;
    logic [OUT_BITS-1:0] o_dat_reg, o_dat_next;
    logic                o_eop_reg, o_eop_next;
    logic [CNT_W-1:0]    o_cnt_reg, o_cnt_next;

    logic                out_free;
    logic                lane_take;
    logic                emit;
    logic [OUT_BITS-1:0] merged;

    // Output register can take a new word when it is empty or being drained.
    // o_rdy depends only on registered state, i_rdy and reset.
    assign out_free  = ~o_val_reg | i_rdy;
    assign o_rdy     = i_rst_n & out_free;
    assign lane_take = i_val & o_rdy;

    // Accumulator with the incoming lane dropped into slot cnt_reg.
    for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
        assign merged[gi*IN_BITS +: IN_BITS] =
            (lane_take && (cnt_reg == CNT_W'(gi))) ? i_dat
                                                   : acc_reg[gi*IN_BITS +: IN_BITS];
    end

    // Emit on a full word, on end-of-packet, or on flush (never an empty word).
    // A flush while the output is held is dropped; the caller re-asserts it.
    assign emit = out_free &
                  ((lane_take & ((cnt_reg == LAST_LANE) | i_eop | i_flush)) |
                   (~lane_take & i_flush & (cnt_reg != '0)));

    // Next-state selection for the lane counter, accumulator and output word.
    always_comb begin
        cnt_next   = cnt_reg;
        acc_next   = acc_reg;
        o_val_next = o_val_reg;
        o_dat_next = o_dat_reg;
        o_eop_next = o_eop_reg;
        o_cnt_next = o_cnt_reg;
        if (emit) begin
            o_val_next = 1'b1;
            o_dat_next = merged;
            o_eop_next = lane_take & i_eop;
            o_cnt_next = lane_take ? (cnt_reg + CNT_ONE) : cnt_reg;
            cnt_next   = '0;
            acc_next   = '0;
        end else begin
            if (lane_take) begin
                cnt_next = cnt_reg + CNT_ONE;
                acc_next = merged;
            end
            if (out_free) begin
                o_val_next = 1'b0;
            end
        end
    end

    // State registers with synchronous active-low reset; reset drops any partial word.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_reg   <= '0;
            acc_reg   <= '0;
            o_val_reg <= 1'b0;
            o_dat_reg <= '0;
            o_eop_reg <= 1'b0;
            o_cnt_reg <= '0;
        end else begin
            cnt_reg   <= cnt_next;
            acc_reg   <= acc_next;
            o_val_reg <= o_val_next;
            o_dat_reg <= o_dat_next;
            o_eop_reg <= o_eop_next;
            o_cnt_reg <= o_cnt_next;
        end
    end

    assign o_val = o_val_reg;
    assign o_dat = o_dat_reg;
    assign o_eop = o_eop_reg;
    assign o_cnt = o_cnt_reg;

endmodule
